// File: rtl/trace_feeder_if.sv
// Request bus between a trace source, the trace feeder and the downstream cache simulator.
// Valid/ready on both sides: a transfer happens on a rising clk edge where valid and ready
// are both 1; a producer raising valid keeps its payload stable until that edge.
interface trace_feeder_if #(
    parameter int ADDRESS_SIZE = 16
);
    logic                    in_valid;
    logic                    in_rw;
    logic [ADDRESS_SIZE-1:0] in_address;
    logic                    in_last;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_rw;
    logic [ADDRESS_SIZE-1:0] out_address;
    logic                    out_ready;

    // Environment view: trace source plus cache-simulator sink.
    modport master (
        output in_valid, in_rw, in_address, in_last, out_ready,
        input  in_ready, out_valid, out_rw, out_address
    );

    // Feeder view.
    modport slave (
        input  in_valid, in_rw, in_address, in_last, out_ready,
        output in_ready, out_valid, out_rw, out_address
    );
endinterface

// File: rtl/trace_feeder.sv
// Buffers a memory-request trace in a small FIFO and issues it to a cache simulator,
// counting issued reads/writes and back-pressure stall cycles for one run per start pulse.
module trace_feeder #(
    parameter int ADDRESS_SIZE = 16,
    parameter int DEPTH        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    trace_feeder_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic [31:0]   num_reads,
    output logic [31:0]   num_writes,
    output logic [31:0]   stall_cycles,
    output logic [1:0]    state_dbg
);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $fatal(1, "trace_feeder: DEPTH must be a power of 2 in 2..64");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PW:0]             wr_ptr_q;
    logic [PW:0]             rd_ptr_q;
    logic [PW-1:0]           wr_idx;
    logic [PW-1:0]           rd_idx;
    logic [DEPTH-1:0]        mem_rw;
    logic [ADDRESS_SIZE-1:0] mem_addr [DEPTH];
    logic [31:0]             num_reads_q;
    logic [31:0]             num_writes_q;
    logic [31:0]             stall_cycles_q;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    clear;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        clear         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                busy          = 1'b1;
                bus.in_ready  = !full;
                bus.out_valid = !empty;
                if (bus.in_valid && !full && bus.in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy          = 1'b1;
                bus.out_valid = !empty;
                // Empty FIFO means out_valid is low, so nothing is left in flight.
                if (empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Head entry is masked so stale storage never leaks onto the bus.
    assign bus.out_rw      = bus.out_valid & mem_rw[rd_idx];
    assign bus.out_address = bus.out_valid ? mem_addr[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rw[wr_idx]   <= bus.in_rw;
            mem_addr[wr_idx] <= bus.in_address;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            num_reads_q    <= '0;
            num_writes_q   <= '0;
            stall_cycles_q <= '0;
        end else if (clear) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            num_reads_q    <= '0;
            num_writes_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (bus.out_rw) begin
                    if (num_writes_q != 32'hFFFF_FFFF) num_writes_q <= num_writes_q + 32'd1;
                end else begin
                    if (num_reads_q != 32'hFFFF_FFFF) num_reads_q <= num_reads_q + 32'd1;
                end
            end
            if (bus.out_valid && !bus.out_ready && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign num_reads    = num_reads_q;
    assign num_writes   = num_writes_q;
    assign stall_cycles = stall_cycles_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_trace_feeder.sv
// Bench for trace_feeder: randomized traces checked cycle by cycle against a queue-based
// model of the run (accept rule, 1-cycle visibility, issue order, saturating counters).
module tb_trace_feeder;
    localparam int AW    = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] num_reads;
    logic [31:0] num_writes;
    logic [31:0] stall_cycles;
    logic [1:0]  state_dbg;

    trace_feeder_if #(.ADDRESS_SIZE(AW)) bus ();

    trace_feeder #(.ADDRESS_SIZE(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .num_reads    (num_reads),
        .num_writes   (num_writes),
        .stall_cycles (stall_cycles),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of the run: queue of accepted {rw, address} in issue order.
    logic [AW:0] exp_q[$];
    bit          m_accepting, m_active, m_done;
    logic [31:0] m_reads, m_writes, m_stalls;

    // Per-cycle samples (DUT) and model predictions, both taken before the edge.
    logic        obs_in_ready, obs_out_valid, obs_busy, obs_done;
    logic [AW:0] obs_payload;
    bit          exp_in_ready, exp_out_valid, exp_busy, exp_done, acc;
    logic [AW:0] exp_head;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_accepting = 1'b0; m_active = 1'b0; m_done = 1'b0;
        m_reads = '0; m_writes = '0; m_stalls = '0;
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic tick(input bit v, input bit rw, input logic [AW-1:0] addr,
                        input bit last, input bit ord, input bit st);
        int          sz;
        bit          was_active, pop, to_done;
        logic [AW:0] head;
        bus.in_valid = v; bus.in_rw = rw; bus.in_address = addr; bus.in_last = last;
        bus.out_ready = ord; start = st;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        obs_payload   = {bus.out_rw, bus.out_address};
        obs_busy      = busy;
        obs_done      = done;
        sz            = exp_q.size();
        was_active    = m_active;
        exp_in_ready  = m_accepting && (sz < DEPTH);
        exp_out_valid = m_active && (sz > 0);
        exp_busy      = m_active;
        exp_done      = m_done;
        exp_head      = (sz > 0) ? exp_q[0] : '0;
        @(posedge clk);
        acc     = v && exp_in_ready;
        pop     = exp_out_valid && ord;
        to_done = m_active && !m_accepting && (sz == 0);
        if (pop) begin
            head = exp_q.pop_front();
            if (head[AW]) m_writes = sat_inc(m_writes);
            else          m_reads  = sat_inc(m_reads);
        end
        if (exp_out_valid && !ord) m_stalls = sat_inc(m_stalls);
        if (acc) begin
            exp_q.push_back({rw, addr});
            if (last) m_accepting = 1'b0;
        end
        if (to_done) begin
            m_active = 1'b0;
            m_done   = 1'b1;
        end
        if (st && !was_active) begin
            exp_q.delete();
            m_reads = '0; m_writes = '0; m_stalls = '0;
            m_accepting = 1'b1; m_active = 1'b1; m_done = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0 (state %0d)", busy, state_dbg); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0 (state %0d)", done, state_dbg); end
        total++; if ({bus.out_rw, bus.out_address} !== '0) begin bad++; $display("FAIL reset_payload: got %h want 0", {bus.out_rw, bus.out_address}); end
        total++; if ({num_reads, num_writes, stall_cycles} !== '0) begin bad++; $display("FAIL reset_counters: got %h %h %h want 0", num_reads, num_writes, stall_cycles); end
        reset = 1'b1;
        // Without a start the feeder must stay idle even with a request offered.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 16'h00AA, 1'b0, 1'b1, 1'b0);
            total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL idle_in_ready: got %b want %b", obs_in_ready, exp_in_ready); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL idle_busy: got %b want %b", obs_busy, exp_busy); end
        end
    endtask

    task automatic test_basic();
        logic [5:0]  vmask;
        logic [AW:0] seen[$];
        vmask = '0;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       tick(1'b1, 1'b0, 16'h1230, 1'b0, 1'b1, 1'b0);
                1:       tick(1'b1, 1'b1, 16'h4560, 1'b1, 1'b1, 1'b0);
                default: tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            endcase
            total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL basic_in_ready: got %b want %b cyc %0d", obs_in_ready, exp_in_ready, i); end
            total++; if (obs_out_valid !== exp_out_valid) begin bad++; $display("FAIL basic_out_valid: got %b want %b cyc %0d", obs_out_valid, exp_out_valid, i); end
            vmask[i] = obs_out_valid;
            if (obs_out_valid === 1'b1) seen.push_back(obs_payload);
        end
        total++; if (vmask !== 6'b000110) begin bad++; $display("FAIL basic_valid_timing: got %b want 000110", vmask); end
        total++; if (seen.size() != 2) begin bad++; $display("FAIL basic_issue_count: got %0d want 2", seen.size()); end
        else begin
            total++; if (seen[0] !== {1'b0, 16'h1230}) begin bad++; $display("FAIL basic_first: got %h want 01230", seen[0]); end
            total++; if (seen[1] !== {1'b1, 16'h4560}) begin bad++; $display("FAIL basic_second: got %h want 14560", seen[1]); end
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done: got done=%b busy=%b want 1 0", done, busy); end
        total++; if (num_reads !== 32'd1 || num_writes !== 32'd1) begin bad++; $display("FAIL basic_counts: got r=%0d w=%0d want 1 1", num_reads, num_writes); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL basic_stalls: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_fill();
        int n_acc = 0;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), 1'b0, 1'b0, 1'b0);
            total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL fill_in_ready: got %b want %b cyc %0d", obs_in_ready, exp_in_ready, i); end
            total++; if (obs_out_valid !== exp_out_valid) begin bad++; $display("FAIL fill_out_valid: got %b want %b cyc %0d", obs_out_valid, exp_out_valid, i); end
            if (obs_in_ready === 1'b1) n_acc++;
        end
        total++; if (n_acc != DEPTH) begin bad++; $display("FAIL fill_accepts: got %0d want %0d", n_acc, DEPTH); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready: got %b want 0", bus.in_ready); end
        total++; if (stall_cycles !== 32'd11) begin bad++; $display("FAIL fill_stalls: got %0d want 11", stall_cycles); end
        total++; if (stall_cycles !== m_stalls) begin bad++; $display("FAIL fill_stalls_model: got %0d want %0d", stall_cycles, m_stalls); end
    endtask

    task automatic test_wrap();
        int          sent = 0;
        int          cyc = 0;
        logic [AW-1:0] a;
        bit          r;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        total++; if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin bad++; $display("FAIL wrap_pulse: got rdy=%b vld=%b want 0 1", obs_in_ready, obs_out_valid); end
        total++; if (obs_payload !== exp_head) begin bad++; $display("FAIL wrap_pulse_head: got %h want %h", obs_payload, exp_head); end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL wrap_slot_free: got %b want 1", obs_in_ready); end
        a = AW'($urandom);
        r = 1'($urandom_range(0, 1));
        while ((sent < 20 || !m_done) && cyc < 800) begin
            tick((sent < 20) && ($urandom_range(0, 3) != 0), r, a, sent == 19, $urandom_range(0, 2) != 0, 1'b0);
            total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL wrap_in_ready: got %b want %b cyc %0d", obs_in_ready, exp_in_ready, cyc); end
            total++; if (obs_out_valid !== exp_out_valid) begin bad++; $display("FAIL wrap_out_valid: got %b want %b cyc %0d", obs_out_valid, exp_out_valid, cyc); end
            if (exp_out_valid) begin
                total++; if (obs_payload !== exp_head) begin bad++; $display("FAIL wrap_payload: got %h want %h cyc %0d", obs_payload, exp_head, cyc); end
            end
            if (acc) begin
                sent++;
                a = AW'($urandom);
                r = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b want 1 after %0d cycles", done, cyc); end
        total++; if (num_reads + num_writes !== 32'd28) begin bad++; $display("FAIL wrap_issued: got %0d want 28", num_reads + num_writes); end
        total++; if (num_reads !== m_reads || num_writes !== m_writes) begin bad++; $display("FAIL wrap_counts: got r=%0d w=%0d want %0d %0d", num_reads, num_writes, m_reads, m_writes); end
        total++; if (stall_cycles !== m_stalls) begin bad++; $display("FAIL wrap_stalls: got %0d want %0d", stall_cycles, m_stalls); end
    endtask

    task automatic test_restart();
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL restart_state: got done=%b busy=%b want 0 1", done, busy); end
        total++; if ({num_reads, num_writes, stall_cycles} !== '0) begin bad++; $display("FAIL restart_counters: got %0d %0d %0d want 0", num_reads, num_writes, stall_cycles); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL restart_in_ready: got %b want 1", bus.in_ready); end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL run_start_ignored: got busy=%b done=%b want 1 0", busy, done); end
    endtask

    task automatic test_random();
        int            sent = 0;
        int            cyc = 0;
        logic [AW-1:0] a;
        bit            r;
        a = AW'($urandom);
        r = 1'($urandom_range(0, 1));
        while ((sent < 24 || !m_done) && cyc < 800) begin
            tick((sent < 24) && ($urandom_range(0, 3) != 0), r, a, sent == 23,
                 $urandom_range(0, 1) != 0, (sent < 24) && ($urandom_range(0, 7) == 0));
            total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL rand_in_ready: got %b want %b cyc %0d", obs_in_ready, exp_in_ready, cyc); end
            total++; if (obs_out_valid !== exp_out_valid) begin bad++; $display("FAIL rand_out_valid: got %b want %b cyc %0d", obs_out_valid, exp_out_valid, cyc); end
            total++; if (obs_busy !== exp_busy || obs_done !== exp_done) begin bad++; $display("FAIL rand_status: got busy=%b done=%b want %b %b cyc %0d", obs_busy, obs_done, exp_busy, exp_done, cyc); end
            if (exp_out_valid) begin
                total++; if (obs_payload !== exp_head) begin bad++; $display("FAIL rand_payload: got %h want %h cyc %0d", obs_payload, exp_head, cyc); end
            end
            if (acc) begin
                sent++;
                a = AW'($urandom);
                r = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rand_done: got %b want 1 after %0d cycles", done, cyc); end
        total++; if (num_reads + num_writes !== 32'd24) begin bad++; $display("FAIL rand_issued: got %0d want 24", num_reads + num_writes); end
        total++; if (num_reads !== m_reads || stall_cycles !== m_stalls) begin bad++; $display("FAIL rand_counts: got r=%0d s=%0d want %0d %0d", num_reads, stall_cycles, m_reads, m_stalls); end
    endtask

    task automatic test_reset_midrun();
        int cyc = 0;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, AW'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        end
        total++; if (bus.out_valid !== 1'b1 || stall_cycles !== m_stalls) begin bad++; $display("FAIL midrun_pre: got vld=%b stalls=%0d want 1 %0d", bus.out_valid, stall_cycles, m_stalls); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrun_async: got vld=%b rdy=%b want 0 0", bus.out_valid, bus.in_ready); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrun_status: got busy=%b done=%b want 0 0", busy, done); end
        total++; if ({num_reads, num_writes, stall_cycles} !== '0) begin bad++; $display("FAIL midrun_counters: got %0d %0d %0d want 0", num_reads, num_writes, stall_cycles); end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 16'h0BAD, 1'b0, 1'b1, 1'b0);
            total++; if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0) begin bad++; $display("FAIL midrun_idle: got rdy=%b vld=%b busy=%b want 0 0 0", obs_in_ready, obs_out_valid, obs_busy); end
        end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, AW'(16'h0200 + i), i == 2, 1'b1, 1'b0);
            total++; if (obs_out_valid !== exp_out_valid) begin bad++; $display("FAIL midrun_new_valid: got %b want %b cyc %0d", obs_out_valid, exp_out_valid, i); end
        end
        while (!m_done && cyc < 50) begin
            tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (exp_out_valid) begin
                total++; if (obs_payload !== exp_head) begin bad++; $display("FAIL midrun_payload: got %h want %h", obs_payload, exp_head); end
            end
            cyc++;
        end
        total++; if (done !== 1'b1 || num_reads !== 32'd3 || num_writes !== 32'd0) begin bad++; $display("FAIL midrun_rerun: got done=%b r=%0d w=%0d want 1 3 0", done, num_reads, num_writes); end
    endtask

    task automatic test_saturate();
        int cyc = 0;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        force dut.num_reads_q = 32'hFFFF_FFFE;
        #1;
        release dut.num_reads_q;
        m_reads = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, AW'(16'h0300 + i), i == 2, 1'b1, 1'b0);
        end
        while (!m_done && cyc < 50) begin
            tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            cyc++;
        end
        total++; if (num_reads !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reads: got %h want ffffffff", num_reads); end
        total++; if (num_reads !== m_reads || num_writes !== 32'd0) begin bad++; $display("FAIL sat_model: got r=%h w=%0d want %h 0", num_reads, num_writes, m_reads); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_done: got %b want 1", done); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_rw = 1'b0; bus.in_address = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_restart();
        test_random();
        test_reset_midrun();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
